// File: rtl/tlb_inv_seq_pkg.sv
// Shared definitions for the INVTLB sequencer: op codes, page sizes, state encoding.
package tlb_inv_seq_pkg;

   localparam int TLBNUM_DEF = 16;
   localparam int IDX_W_DEF  = 4;

   localparam logic [4:0] INV_OP_ALL0     = 5'd0;
   localparam logic [4:0] INV_OP_ALL1     = 5'd1;
   localparam logic [4:0] INV_OP_G        = 5'd2;
   localparam logic [4:0] INV_OP_NG       = 5'd3;
   localparam logic [4:0] INV_OP_ASID     = 5'd4;
   localparam logic [4:0] INV_OP_ASID_VA  = 5'd5;
   localparam logic [4:0] INV_OP_GASID_VA = 5'd6;
   localparam logic [4:0] INV_OP_MAX      = 5'd6;

   localparam logic [5:0] PS_4K    = 6'd12;
   localparam logic [5:0] PS_LARGE = 6'd21;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WALK = 2'd1,
      ST_DONE = 2'd2
   } inv_state_e;

endpackage

// File: rtl/tlb_inv_match.sv
// Combinational INVTLB match: decides whether one TLB entry is invalidated by an op.
module tlb_inv_match
   import tlb_inv_seq_pkg::*;
(
   input  logic [4:0]  op,
   input  logic        ent_e,
   input  logic        ent_g,
   input  logic [9:0]  ent_asid,
   input  logic [5:0]  ent_ps,
   input  logic [18:0] ent_vppn,
   input  logic [9:0]  asid,
   input  logic [18:0] vppn,
   output logic        hit
);

   logic va_hit;
   logic asid_hit;
   logic sel;

   always_comb begin
      // Large pages only carry the upper ten VPPN bits.
      if (ent_ps == PS_LARGE) begin
         va_hit = (ent_vppn[18:9] == vppn[18:9]);
      end else begin
         va_hit = (ent_vppn == vppn);
      end
      asid_hit = (ent_asid == asid);

      sel = 1'b0;
      case (op)
         INV_OP_ALL0, INV_OP_ALL1: sel = 1'b1;
         INV_OP_G:                 sel = ent_g;
         INV_OP_NG:                sel = ~ent_g;
         INV_OP_ASID:              sel = ~ent_g & asid_hit;
         INV_OP_ASID_VA:           sel = ~ent_g & asid_hit & va_hit;
         INV_OP_GASID_VA:          sel = (ent_g | asid_hit) & va_hit;
         default:                  sel = 1'b0;
      endcase

      hit = ent_e & sel;
   end

endmodule

// File: rtl/tlb_inv_seq.sv
// INVTLB sequencer: walks every TLB entry through the shared port, clearing E on matches.
//
// state   | meaning
// IDLE    | waiting for an INVTLB request from WB
// WALK    | owns the TLB port, one entry per cycle
// DONE    | one-cycle completion pulse, then back to IDLE
module tlb_inv_seq
   import tlb_inv_seq_pkg::*;
#(
   parameter int TLBNUM = TLBNUM_DEF,
   parameter int IDX_W  = IDX_W_DEF
) (
   input  logic             clk,
   input  logic             resetn,

   input  logic             inv_req,
   input  logic [4:0]       inv_op,
   input  logic [9:0]       inv_asid,
   input  logic [31:0]      inv_va,
   output logic             inv_busy,
   output logic             inv_done,
   output logic             inv_ineop,

   output logic             tlb_port_own,
   output logic [IDX_W-1:0] r_index,
   input  logic             r_e,
   input  logic [18:0]      r_vppn,
   input  logic [5:0]       r_ps,
   input  logic [9:0]       r_asid,
   input  logic             r_g,
   input  logic [19:0]      r_ppn0,
   input  logic [1:0]       r_plv0,
   input  logic [1:0]       r_mat0,
   input  logic             r_d0,
   input  logic             r_v0,
   input  logic [19:0]      r_ppn1,
   input  logic [1:0]       r_plv1,
   input  logic [1:0]       r_mat1,
   input  logic             r_d1,
   input  logic             r_v1,

   output logic             we,
   output logic [IDX_W-1:0] w_index,
   output logic             w_e,
   output logic [18:0]      w_vppn,
   output logic [5:0]       w_ps,
   output logic [9:0]       w_asid,
   output logic             w_g,
   output logic [19:0]      w_ppn0,
   output logic [1:0]       w_plv0,
   output logic [1:0]       w_mat0,
   output logic             w_d0,
   output logic             w_v0,
   output logic [19:0]      w_ppn1,
   output logic [1:0]       w_plv1,
   output logic [1:0]       w_mat1,
   output logic             w_d1,
   output logic             w_v1
);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TLBNUM - 1);

   inv_state_e       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [4:0]       op_q, op_d;
   logic [9:0]       asid_q, asid_d;
   logic [18:0]      vppn_q, vppn_d;
   logic             ineop_q, ineop_d;

   logic             walk;
   logic             done;
   logic             hit;
   logic             unused_va;

   // Page offset bits of the VA operand never take part in matching.
   assign unused_va = ^inv_va[12:0];

   tlb_inv_match u_match (
      .op       (op_q),
      .ent_e    (r_e),
      .ent_g    (r_g),
      .ent_asid (r_asid),
      .ent_ps   (r_ps),
      .ent_vppn (r_vppn),
      .asid     (asid_q),
      .vppn     (vppn_q),
      .hit      (hit)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         op_q    <= '0;
         asid_q  <= '0;
         vppn_q  <= '0;
         ineop_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         op_q    <= op_d;
         asid_q  <= asid_d;
         vppn_q  <= vppn_d;
         ineop_q <= ineop_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      op_d    = op_q;
      asid_d  = asid_q;
      vppn_d  = vppn_q;
      ineop_d = 1'b0;
      walk    = 1'b0;
      done    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (inv_req) begin
               if (inv_op <= INV_OP_MAX) begin
                  op_d    = inv_op;
                  asid_d  = inv_asid;
                  vppn_d  = inv_va[31:13];
                  idx_d   = '0;
                  state_d = ST_WALK;
               end else begin
                  ineop_d = 1'b1;
               end
            end
         end
         ST_WALK: begin
            walk = 1'b1;
            if (idx_q == IDX_LAST) begin
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      inv_busy     = (state_q != ST_IDLE);
      inv_done     = done;
      inv_ineop    = ineop_q;
      tlb_port_own = walk;
      r_index      = walk ? idx_q : '0;
      w_index      = walk ? idx_q : '0;
      we           = walk & hit;
      w_e          = 1'b0;
      // Write data is the entry read back unchanged; only E is forced low.
      w_vppn = walk ? r_vppn : '0;
      w_ps   = walk ? r_ps   : '0;
      w_asid = walk ? r_asid : '0;
      w_g    = walk & r_g;
      w_ppn0 = walk ? r_ppn0 : '0;
      w_plv0 = walk ? r_plv0 : '0;
      w_mat0 = walk ? r_mat0 : '0;
      w_d0   = walk & r_d0;
      w_v0   = walk & r_v0;
      w_ppn1 = walk ? r_ppn1 : '0;
      w_plv1 = walk ? r_plv1 : '0;
      w_mat1 = walk ? r_mat1 : '0;
      w_d1   = walk & r_d1;
      w_v1   = walk & r_v1;
   end

endmodule

// File: tb/tb_tlb_inv_seq.sv
// Self-checking bench for tlb_inv_seq: behavioural TLB memory plus reference invalidate model.
module tb_tlb_inv_seq;
   import tlb_inv_seq_pkg::*;

   localparam int N = 16;

   typedef struct packed {
      logic        e;
      logic [18:0] vppn;
      logic [5:0]  ps;
      logic [9:0]  asid;
      logic        g;
      logic [19:0] ppn0;
      logic [1:0]  plv0;
      logic [1:0]  mat0;
      logic        d0;
      logic        v0;
      logic [19:0] ppn1;
      logic [1:0]  plv1;
      logic [1:0]  mat1;
      logic        d1;
      logic        v1;
   } ent_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   logic        inv_req = 1'b0;
   logic [4:0]  inv_op = '0;
   logic [9:0]  inv_asid = '0;
   logic [31:0] inv_va = '0;
   logic        inv_busy, inv_done, inv_ineop, tlb_port_own;
   logic [3:0]  r_index, w_index;
   logic        r_e, r_g, r_d0, r_v0, r_d1, r_v1;
   logic [18:0] r_vppn;
   logic [5:0]  r_ps;
   logic [9:0]  r_asid;
   logic [19:0] r_ppn0, r_ppn1;
   logic [1:0]  r_plv0, r_mat0, r_plv1, r_mat1;
   logic        we, w_e, w_g, w_d0, w_v0, w_d1, w_v1;
   logic [18:0] w_vppn;
   logic [5:0]  w_ps;
   logic [9:0]  w_asid;
   logic [19:0] w_ppn0, w_ppn1;
   logic [1:0]  w_plv0, w_mat0, w_plv1, w_mat1;

   ent_t tlb [N];
   ent_t rd;
   logic [3:0] wr_q [$];
   int we_bad = 0;
   int checks = 0;
   int errors = 0;

   assign rd     = tlb[r_index];
   assign r_e    = rd.e;
   assign r_vppn = rd.vppn;
   assign r_ps   = rd.ps;
   assign r_asid = rd.asid;
   assign r_g    = rd.g;
   assign r_ppn0 = rd.ppn0;
   assign r_plv0 = rd.plv0;
   assign r_mat0 = rd.mat0;
   assign r_d0   = rd.d0;
   assign r_v0   = rd.v0;
   assign r_ppn1 = rd.ppn1;
   assign r_plv1 = rd.plv1;
   assign r_mat1 = rd.mat1;
   assign r_d1   = rd.d1;
   assign r_v1   = rd.v1;

   tlb_inv_seq dut (
      .clk(clk), .resetn(resetn),
      .inv_req(inv_req), .inv_op(inv_op), .inv_asid(inv_asid), .inv_va(inv_va),
      .inv_busy(inv_busy), .inv_done(inv_done), .inv_ineop(inv_ineop),
      .tlb_port_own(tlb_port_own), .r_index(r_index),
      .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid), .r_g(r_g),
      .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0), .r_d0(r_d0), .r_v0(r_v0),
      .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1), .r_d1(r_d1), .r_v1(r_v1),
      .we(we), .w_index(w_index), .w_e(w_e), .w_vppn(w_vppn), .w_ps(w_ps),
      .w_asid(w_asid), .w_g(w_g),
      .w_ppn0(w_ppn0), .w_plv0(w_plv0), .w_mat0(w_mat0), .w_d0(w_d0), .w_v0(w_v0),
      .w_ppn1(w_ppn1), .w_plv1(w_plv1), .w_mat1(w_mat1), .w_d1(w_d1), .w_v1(w_v1)
   );

   // TLB storage: written by the DUT port, or by the bench while the DUT is idle.
   always @(posedge clk) begin
      if (we === 1'b1) begin
         tlb[w_index] <= '{e: w_e, vppn: w_vppn, ps: w_ps, asid: w_asid, g: w_g,
                           ppn0: w_ppn0, plv0: w_plv0, mat0: w_mat0, d0: w_d0, v0: w_v0,
                           ppn1: w_ppn1, plv1: w_plv1, mat1: w_mat1, d1: w_d1, v1: w_v1};
         wr_q.push_back(w_index);
         if (w_e !== 1'b0) we_bad++;
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference rule: which entries an INVTLB op removes.
   function automatic bit ref_hit(ent_t en, int op, logic [9:0] asid, logic [31:0] va);
      int  sh;
      bit  vam, am;
      sh  = (en.ps == 6'd21) ? 9 : 0;
      vam = ((int'(en.vppn) >> sh) == (int'(va >> 13) >> sh));
      am  = (en.asid == asid);
      if (!en.e) return 1'b0;
      case (op)
         0, 1:    return 1'b1;
         2:       return en.g;
         3:       return !en.g;
         4:       return !en.g && am;
         5:       return !en.g && am && vam;
         6:       return (en.g || am) && vam;
         default: return 1'b0;
      endcase
   endfunction

   function automatic ent_t rand_bits();
      logic [95:0] rb;
      rb = {$urandom(), $urandom(), $urandom()};
      return ent_t'(rb[88:0]);
   endfunction

   function automatic ent_t base_ent();
      ent_t en;
      en      = rand_bits();
      en.e    = 1'b1;
      en.g    = 1'b0;
      en.asid = 10'h3FF;
      en.ps   = 6'd12;
      en.vppn = '0;
      return en;
   endfunction

   function automatic ent_t rand_ent(logic [18:0] vbase);
      ent_t en;
      en      = rand_bits();
      en.e    = ($urandom_range(0, 3) != 0);
      en.g    = $urandom_range(0, 1);
      en.ps   = ($urandom_range(0, 1) != 0) ? 6'd21 : 6'd12;
      en.asid = ($urandom_range(0, 2) == 0) ? 10'($urandom()) : 10'($urandom_range(1, 2));
      case ($urandom_range(0, 2))
         0:       en.vppn = vbase;
         1:       en.vppn = vbase ^ 19'($urandom_range(1, 511));
         default: en.vppn = 19'($urandom());
      endcase
      return en;
   endfunction

   task automatic run_inv(input string tag, input int op, input logic [9:0] asid,
                          input logic [31:0] va);
      ent_t       exp [N];
      logic [3:0] exp_w [$];
      int         cyc;
      for (int i = 0; i < N; i++) begin
         exp[i] = tlb[i];
         if (ref_hit(tlb[i], op, asid, va)) begin
            exp[i].e = 1'b0;
            exp_w.push_back(4'(i));
         end
      end
      wr_q.delete();
      we_bad = 0;
      @(negedge clk);
      inv_req = 1'b1; inv_op = 5'(op); inv_asid = asid; inv_va = va;
      @(negedge clk);
      inv_req = 1'b0;
      check({tag, "/start"}, {inv_busy, tlb_port_own, r_index}, {1'b1, 1'b1, 4'd0});
      cyc = 1;
      while (!inv_done && cyc < 40) begin
         // Operand changes and a stray request mid-walk must be ignored.
         inv_op   = 5'($urandom());
         inv_asid = 10'($urandom());
         inv_va   = $urandom();
         inv_req  = (cyc == 5);
         @(negedge clk);
         cyc++;
      end
      inv_req = 1'b0;
      check({tag, "/latency"}, 128'(cyc), 128'(N + 1));
      @(negedge clk);
      check({tag, "/idle"}, {inv_busy, inv_done, tlb_port_own, we}, 4'b0000);
      check({tag, "/nwrites"}, 128'(wr_q.size()), 128'(exp_w.size()));
      for (int k = 0; k < exp_w.size() && k < wr_q.size(); k++)
         check($sformatf("%s/widx%0d", tag, k), 128'(wr_q[k]), 128'(exp_w[k]));
      check({tag, "/w_e"}, 128'(we_bad), 128'(0));
      for (int i = 0; i < N; i++)
         check($sformatf("%s/ent%0d", tag, i), 128'(tlb[i]), 128'(exp[i]));
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      ent_t       en;
      logic [9:0] ra;
      logic [31:0] rva;
      int         cyc;

      for (int i = 0; i < N; i++) tlb[i] <= base_ent();
      #12;
      check("reset_outputs",
            {inv_busy, inv_done, inv_ineop, tlb_port_own, r_index, we, w_index, w_e,
             w_vppn, w_asid, w_ppn0, w_ppn1},
            '0);
      @(negedge clk);
      resetn = 1'b1;

      // Op 0: every valid entry cleared, in index order.
      run_inv("op0_all", 0, 10'h000, 32'h0);

      // Op 2: only global entries 3 and 9.
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         en = base_ent();
         en.g = (i == 3 || i == 9);
         tlb[i] <= en;
      end
      #1;
      run_inv("op2_g", 2, 10'h000, 32'h0);

      // Op 4: only entry 2 (asid match, non-global).
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         en = base_ent();
         if (i == 2) begin en.asid = 10'h005; en.g = 1'b0; end
         if (i == 4) begin en.asid = 10'h005; en.g = 1'b1; end
         if (i == 6) begin en.asid = 10'h006; en.g = 1'b0; end
         tlb[i] <= en;
      end
      #1;
      run_inv("op4_asid", 4, 10'h005, 32'h0);

      // Op 6: global 4K hit, large-page hit on upper VPPN bits, 4K near-miss.
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         en = base_ent();
         if (i == 1) begin en.g = 1'b1; en.ps = 6'd12; en.vppn = 19'h091A2; end
         if (i == 7) begin en.asid = 10'h001; en.ps = 6'd21; en.vppn = 19'h09000; end
         if (i == 8) begin en.asid = 10'h001; en.ps = 6'd12; en.vppn = 19'h091A3; end
         tlb[i] <= en;
      end
      #1;
      run_inv("op6_va", 6, 10'h001, 32'h12345000);
      check("op6_e1", 128'(tlb[1].e), 128'(0));
      check("op6_e7", 128'(tlb[7].e), 128'(0));
      check("op6_e8", 128'(tlb[8].e), 128'(1));

      // Op 7: illegal, one-cycle ineop pulse and no walk.
      @(negedge clk);
      wr_q.delete();
      inv_req = 1'b1; inv_op = 5'd7;
      @(negedge clk);
      inv_req = 1'b0;
      check("op7_pulse", {inv_ineop, inv_busy, tlb_port_own}, 3'b100);
      @(negedge clk);
      check("op7_after", {inv_ineop, inv_busy, inv_done}, 3'b000);
      check("op7_nowrite", 128'(wr_q.size()), 128'(0));

      // Randomized ops 0..6 over random tables.
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         ra  = 10'($urandom_range(1, 2));
         rva = $urandom();
         for (int i = 0; i < N; i++) tlb[i] <= rand_ent(rva[31:13]);
         #1;
         run_inv($sformatf("rnd%0d", t), int'($urandom_range(0, 6)), ra, rva);
      end

      // Reset during the walk at idx 5.
      @(negedge clk);
      for (int i = 0; i < N; i++) tlb[i] <= base_ent();
      @(negedge clk);
      inv_req = 1'b1; inv_op = 5'd0;
      @(negedge clk);
      inv_req = 1'b0;
      cyc = 0;
      while (r_index != 4'd5 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check("rst_reach_idx5", 128'(r_index), 128'(5));
      resetn = 1'b0;
      #1;
      check("rst_async_out", {inv_busy, inv_done, tlb_port_own, we, r_index}, '0);
      for (int i = 0; i < N; i++)
         check($sformatf("rst_ent%0d_e", i), 128'(tlb[i].e), 128'(i >= 5));
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rst_no_done", {inv_done, inv_busy}, 2'b00);
      end
      resetn = 1'b1;
      for (int i = 0; i < N; i++) tlb[i] <= base_ent();
      #1;
      run_inv("post_rst", 0, 10'h000, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
